// File: rtl/ks_subtractor_pipe_if.sv
// Operand/result handshake bundle for the pipelined Kogge-Stone subtractor.
// slave = the subtractor, master = whoever feeds and drains it.
interface ks_subtractor_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

// File: rtl/ks_subtractor_pipe.sv
// Three-stage Kogge-Stone subtractor (a - b - bin); result valid three edges after accept.
// Valid/ready per stage; in_ready is combinational from out_ready so a full pipe streams without bubbles.
module ks_subtractor_pipe #(
  parameter int WIDTH  = 16,
  parameter int LEVELS = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  ks_subtractor_pipe_if.slave io_bus
);
  localparam int L1 = (LEVELS + 1) / 2;

  logic r_v1, r_v2, r_v3;
  logic w_adv1, w_adv2, w_adv3;
  logic w_ld1, w_ld2, w_ld3;

  assign w_adv3          = r_v3 & io_bus.out_ready;
  assign w_ld3           = r_v2 & (~r_v3 | w_adv3);
  assign w_adv2          = w_ld3;
  assign w_ld2           = r_v1 & (~r_v2 | w_adv2);
  assign w_adv1          = w_ld2;
  assign io_bus.in_ready = ~i_rst & (~r_v1 | w_adv1);
  assign w_ld1           = io_bus.in_valid & io_bus.in_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_ld1)       r_v1 <= 1'b1;
      else if (w_adv1) r_v1 <= 1'b0;
      if (w_ld2)       r_v2 <= 1'b1;
      else if (w_adv2) r_v2 <= 1'b0;
      if (w_ld3)       r_v3 <= 1'b1;
      else if (w_adv3) r_v3 <= 1'b0;
    end
  end

  // Stage 1: per-bit generate/propagate against the inverted subtrahend.
  logic [WIDTH-1:0] w_bn;
  logic [WIDTH-1:0] r1_p, r1_g;
  logic             r1_cin, r1_amsb, r1_bmsb;

  assign w_bn = ~io_bus.b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r1_p    <= '0;
      r1_g    <= '0;
      r1_cin  <= 1'b0;
      r1_amsb <= 1'b0;
      r1_bmsb <= 1'b0;
    end else if (w_ld1) begin
      r1_p    <= io_bus.a ^ w_bn;
      r1_g    <= io_bus.a & w_bn;
      r1_cin  <= ~io_bus.bin;
      r1_amsb <= io_bus.a[WIDTH-1];
      r1_bmsb <= io_bus.b[WIDTH-1];
    end
  end

  // Prefix network; levels below L1 feed from stage 1, the rest from stage 2.
  logic [WIDTH-1:0] w_g [0:LEVELS];
  logic [WIDTH-1:0] w_p [0:LEVELS-1];
  logic [WIDTH-1:0] r2_g, r2_p, r2_pb;
  logic             r2_cin, r2_amsb, r2_bmsb;

  // Carry-in enters as the group generate of bit 0 (i.e. G[0:-1]).
  assign w_g[0] = {r1_g[WIDTH-1:1], r1_g[0] | (r1_p[0] & r1_cin)};
  assign w_p[0] = r1_p;

  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_lvl
    localparam int SPAN = 1 << lv;
    logic [WIDTH-1:0] w_gi, w_pi;

    if (lv == L1) begin : g_src_s2
      assign w_gi = r2_g;
      assign w_pi = r2_p;
    end else begin : g_src_chain
      assign w_gi = w_g[lv];
      assign w_pi = w_p[lv];
    end

    assign w_g[lv+1][SPAN-1:0]     = w_gi[SPAN-1:0];
    assign w_g[lv+1][WIDTH-1:SPAN] = w_gi[WIDTH-1:SPAN]
                                   | (w_pi[WIDTH-1:SPAN] & w_gi[WIDTH-1-SPAN:0]);
    if (lv + 1 < LEVELS) begin : g_prop
      assign w_p[lv+1][SPAN-1:0]     = w_pi[SPAN-1:0];
      assign w_p[lv+1][WIDTH-1:SPAN] = w_pi[WIDTH-1:SPAN] & w_pi[WIDTH-1-SPAN:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r2_g    <= '0;
      r2_p    <= '0;
      r2_pb   <= '0;
      r2_cin  <= 1'b0;
      r2_amsb <= 1'b0;
      r2_bmsb <= 1'b0;
    end else if (w_ld2) begin
      r2_g    <= w_g[L1];
      r2_p    <= w_p[L1];
      r2_pb   <= r1_p;
      r2_cin  <= r1_cin;
      r2_amsb <= r1_amsb;
      r2_bmsb <= r1_bmsb;
    end
  end

  // Stage 3: sum bits and flags from the completed carries.
  logic [WIDTH-1:0] w_c, w_diff;
  logic             w_bout, w_ovf, w_zero;
  logic [WIDTH-1:0] r3_diff;
  logic             r3_bout, r3_ovf, r3_zero;

  assign w_c    = w_g[LEVELS];
  assign w_diff = r2_pb ^ {w_c[WIDTH-2:0], r2_cin};
  assign w_bout = ~w_c[WIDTH-1];
  assign w_ovf  = (r2_amsb ^ r2_bmsb) & (w_diff[WIDTH-1] ^ r2_amsb);
  assign w_zero = ~|w_diff;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r3_diff <= '0;
      r3_bout <= 1'b0;
      r3_ovf  <= 1'b0;
      r3_zero <= 1'b0;
    end else if (w_ld3) begin
      r3_diff <= w_diff;
      r3_bout <= w_bout;
      r3_ovf  <= w_ovf;
      r3_zero <= w_zero;
    end
  end

  assign io_bus.out_valid = r_v3;
  assign io_bus.diff      = r3_diff;
  assign io_bus.bout      = r3_bout;
  assign io_bus.ovf       = r3_ovf;
  assign io_bus.zero      = r3_zero;
endmodule

// File: tb/tb_ks_subtractor_pipe.sv
// Bench for ks_subtractor_pipe: directed table, back-pressure and reset sequences, random traffic vs arithmetic model.
module tb_ks_subtractor_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ks_subtractor_pipe_if #(.WIDTH(16)) bus ();

  ks_subtractor_pipe #(.WIDTH(16), .LEVELS(4)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [18:0] exp_q [$];
  logic        last_acc, last_drn;
  logic        prev_hold = 1'b0;
  logic [19:0] prev_out  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Plain-integer reference: {diff, bout, ovf, zero}.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] u;
    int          s;
    logic [15:0] d;
    logic        ov;
    u  = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    d  = u[15:0];
    s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
    ov = (s > 32767) || (s < -32768);
    return {d, u[16], ov, (d == 16'd0)};
  endfunction

  // One clock: sample at the falling edge, score, then step to just after the rising edge.
  task automatic cycle();
    logic [19:0] cur;
    @(negedge clk);
    cur = {bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.zero};
    if (prev_hold) chk("hold_stable", 32'(cur), 32'(prev_out));
    last_acc = bus.in_valid & bus.in_ready;
    last_drn = bus.out_valid & bus.out_ready;
    if (last_drn) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got %0h with nothing outstanding", cur[18:0]);
      end else begin
        chk("result", 32'(cur[18:0]), 32'(exp_q.pop_front()));
      end
    end
    if (last_acc) exp_q.push_back(model(bus.a, bus.b, bus.bin));
    prev_hold = bus.out_valid & ~bus.out_ready;
    prev_out  = cur;
    @(posedge clk);
    #1;
  endtask

  vec_t        tbl [9];
  logic [15:0] bp_a [5];
  logic [15:0] bp_b [5];
  int          k, lat, drains, cyc, stale;

  initial begin
    tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_outputs", 32'({bus.diff, bus.bout, bus.ovf, bus.zero}), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    // Directed table: one operand set at a time, latency and values checked.
    for (int i = 0; i < 9; i++) begin
      bus.a         = tbl[i].a;
      bus.b         = tbl[i].b;
      bus.bin       = tbl[i].bin;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      cycle();
      chk("vec_accept", 32'(last_acc), 1);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
        cycle();
        lat++;
      end
      chk("vec_latency", lat, 3);
      chk("vec_diff", 32'(bus.diff), 32'(tbl[i].d));
      chk("vec_bout", 32'(bus.bout), 32'(tbl[i].bo));
      chk("vec_ovf", 32'(bus.ovf), 32'(tbl[i].ov));
      chk("vec_zero", 32'(bus.zero), 32'(tbl[i].z));
      cycle();
    end

    // Back-pressure: five sets offered against a stalled consumer.
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = 16'($urandom);
      bp_b[i] = 16'($urandom);
    end
    bus.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = (k < 5);
      if (k < 5) begin
        bus.a   = bp_a[k];
        bus.b   = bp_b[k];
        bus.bin = k[0];
      end
      cycle();
      k += int'(last_acc);
    end
    chk("bp_accepted", k, 3);
    chk("bp_in_ready_low", 32'(bus.in_ready), 0);
    chk("bp_out_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    drains = 0;
    cyc    = 0;
    while (drains < 5 && cyc < 20) begin
      bus.in_valid = (k < 5);
      if (k < 5) begin
        bus.a   = bp_a[k];
        bus.b   = bp_b[k];
        bus.bin = k[0];
      end
      cycle();
      k      += int'(last_acc);
      drains += int'(last_drn);
      cyc++;
    end
    chk("bp_drained", drains, 5);
    chk("bp_one_per_cycle", cyc, 5);
    bus.in_valid = 1'b0;

    // Reset with two results in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'h00F0 + 16'(i);
      bus.b        = 16'h000F;
      bus.bin      = 1'b0;
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_outputs", 32'({bus.diff, bus.bout, bus.ovf, bus.zero}), 0);
    exp_q.delete();
    prev_hold     = 1'b0;
    bus.out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      stale += int'(last_drn);
    end
    chk("midrst_no_stale", stale, 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.a         = 16'($urandom);
      bus.b         = ($urandom_range(0, 7) == 0) ? bus.a : 16'($urandom);
      bus.bin       = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      cycle();
      cyc++;
    end
    chk("final_drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
